// File: rtl/peripheral_muldiv.sv
// Memory-mapped iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional signed operation (FIX state, negation logic) is built when MULDIV_SIGNED_EN is defined.
module peripheral_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  localparam int CW = $clog2(WIDTH);
`ifdef MULDIV_SIGNED_EN
  localparam logic SIGNED_SUP = 1'b1;
`else
  localparam logic SIGNED_SUP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef MULDIV_SIGNED_EN
    ST_FIX  = 2'd2,
`endif
    ST_RUN  = 2'd1
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              op_q, op_d, sgn_q, sgn_d, done_q, done_d, dbz_q, dbz_d;
  logic [31:0]       res_lo_q, res_lo_d, res_hi_q, res_hi_d, d_out_q, d_out_d;

  logic              wr_en_s, rd_en_s, start_s, busy_s, sgn_req_s, b_zero_s, last_s;
  logic [2:0]        sel_s;
  logic [WIDTH-1:0]  abs_a_s, abs_b_s, step_hi_s, step_lo_s;
  logic [WIDTH:0]    mul_sum_s, div_shift_s, div_diff_s;
  logic              div_ge_s;
  logic [63:0]       run_res_s;
  logic [31:0]       rd_data_s;
  logic              unused_s;

  // Extend the low w bits of v to 64 bits, filling the upper bits with fill.
  function automatic logic [63:0] ext64(input logic [63:0] v, input int unsigned w, input logic fill);
    logic [63:0] mask;
    mask = ~((64'd1 << w) - 64'd1);
    if (fill) begin
      ext64 = v | mask;
    end else begin
      ext64 = v & ~mask;
    end
  endfunction

  // Pack a finished result as {RES_HI, RES_LO}; for divide hi is the remainder and lo the quotient.
  function automatic logic [63:0] fmt_result(input logic is_div, input logic is_sgn,
                                             input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
    logic [2*WIDTH-1:0] prod;
    logic [63:0]        q64, r64;
    prod = {hi, lo};
    q64  = ext64(64'(lo), WIDTH, is_sgn & lo[WIDTH-1]);
    r64  = ext64(64'(hi), WIDTH, is_sgn & hi[WIDTH-1]);
    if (is_div) begin
      fmt_result = {r64[31:0], q64[31:0]};
    end else begin
      fmt_result = ext64(64'(prod), 2 * WIDTH, is_sgn & prod[2*WIDTH-1]);
    end
  endfunction

  assign wr_en_s  = cs & wr;
  assign rd_en_s  = cs & rd;
  assign sel_s    = addr[4:2];
  assign start_s  = wr_en_s & (sel_s == 3'd2) & ~busy_s;
  assign b_zero_s = (b_q == {WIDTH{1'b0}});
  assign last_s   = (cnt_q == {CW{1'b0}});
  assign unused_s = &{1'b0, addr, d_in};

`ifdef MULDIV_SIGNED_EN
  assign sgn_req_s = d_in[1];
`else
  assign sgn_req_s = 1'b0;
`endif

  assign abs_a_s = (sgn_req_s & a_q[WIDTH-1]) ? (~a_q + WIDTH'(1'b1)) : a_q;
  assign abs_b_s = (sgn_req_s & b_q[WIDTH-1]) ? (~b_q + WIDTH'(1'b1)) : b_q;

  // One iteration: multiply adds the multiplicand into the high half and shifts right,
  // divide shifts the next dividend bit into the partial remainder and trial-subtracts.
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    div_shift_s = {hi_q, lo_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_q};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    if (op_q) begin
      step_hi_s = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
      step_lo_s = {lo_q[WIDTH-2:0], div_ge_s};
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end
    run_res_s = fmt_result(op_q, 1'b0, step_hi_s, step_lo_s);
  end

`ifdef MULDIV_SIGNED_EN
  logic [2*WIDTH-1:0] fix_prod_s;
  logic [WIDTH-1:0]   fix_q_s, fix_r_s;
  logic [63:0]        fix_res_s;

  // Apply the operand signs to the magnitude result; divide-by-zero keeps its raw pattern.
  always_comb begin
    if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
      fix_prod_s = ~{hi_q, lo_q} + (2*WIDTH)'(1'b1);
      fix_q_s    = ~lo_q + WIDTH'(1'b1);
    end else begin
      fix_prod_s = {hi_q, lo_q};
      fix_q_s    = lo_q;
    end
    if (b_zero_s) begin
      fix_q_s = {WIDTH{1'b1}};
      fix_r_s = a_q;
    end else if (a_q[WIDTH-1]) begin
      fix_r_s = ~hi_q + WIDTH'(1'b1);
    end else begin
      fix_r_s = hi_q;
    end
    if (op_q) begin
      fix_res_s = fmt_result(1'b1, 1'b1, fix_r_s, fix_q_s);
    end else begin
      fix_res_s = fmt_result(1'b0, 1'b1, fix_prod_s[2*WIDTH-1:WIDTH], fix_prod_s[WIDTH-1:0]);
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!last_s) begin
          state_d = ST_RUN;
`ifdef MULDIV_SIGNED_EN
        end else if (sgn_q) begin
          state_d = ST_FIX;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef MULDIV_SIGNED_EN
      ST_FIX:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_s = (state_q != ST_IDLE);
  end

  // Datapath and register-file next state.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    done_d   = done_q;
    dbz_d    = dbz_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    if (wr_en_s && !busy_s && (sel_s == 3'd0)) begin
      a_d = d_in[WIDTH-1:0];
    end else if (wr_en_s && !busy_s && (sel_s == 3'd1)) begin
      b_d = d_in[WIDTH-1:0];
    end else begin
      a_d = a_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          op_d   = d_in[0];
          sgn_d  = sgn_req_s;
          hi_d   = {WIDTH{1'b0}};
          lo_d   = d_in[0] ? abs_a_s : abs_b_s;
          opnd_d = d_in[0] ? abs_b_s : abs_a_s;
          cnt_d  = CW'(WIDTH - 1);
          done_d = 1'b0;
          dbz_d  = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RUN: begin
        hi_d  = step_hi_s;
        lo_d  = step_lo_s;
        cnt_d = cnt_q - CW'(1);
        if (last_s && !sgn_q) begin
          res_lo_d = run_res_s[31:0];
          res_hi_d = run_res_s[63:32];
          done_d   = 1'b1;
          dbz_d    = op_q & b_zero_s;
        end else begin
          done_d = done_q;
        end
      end
`ifdef MULDIV_SIGNED_EN
      ST_FIX: begin
        res_lo_d = fix_res_s[31:0];
        res_hi_d = fix_res_s[63:32];
        done_d   = 1'b1;
        dbz_d    = op_q & b_zero_s;
      end
`endif
      default: begin
        done_d = done_q;
      end
    endcase
  end

  // Read mux; reads see the register contents from before this cycle's write.
  always_comb begin
    case (sel_s)
      3'd0:    rd_data_s = 32'(a_q);
      3'd1:    rd_data_s = 32'(b_q);
      3'd3:    rd_data_s = {28'd0, SIGNED_SUP, dbz_q, done_q, busy_s};
      3'd4:    rd_data_s = res_lo_q;
      3'd5:    rd_data_s = res_hi_q;
      default: rd_data_s = 32'd0;
    endcase
    if (rd_en_s) begin
      d_out_d = rd_data_s;
    end else begin
      d_out_d = d_out_q;
    end
  end

  // Datapath and register-file storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      op_q     <= 1'b0;
      sgn_q    <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
      d_out_q  <= 32'd0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      d_out_q  <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_muldiv.sv
// Scoreboard bench for peripheral_muldiv: reads push expected values, a negedge monitor compares d_out.
// The reference model computes results with plain integer arithmetic and tracks busy windows by edge count.
module tb_peripheral_muldiv;
  localparam int W = 16;
`ifdef MULDIV_SIGNED_EN
  localparam logic SGN_SUP = 1'b1;
`else
  localparam logic SGN_SUP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] d_in = 32'd0;
  logic        cs = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] d_out;

  always #5 clk = ~clk;

  peripheral_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs),
    .addr(addr), .rd(rd), .wr(wr), .d_out(d_out)
  );

  int          checks = 0;
  int          errors = 0;
  longint      edge_cnt = 0;
  logic        rd_seen = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  // Reference model state.
  logic [W-1:0] m_a, m_b;
  logic         m_act;
  longint       m_n;
  int           m_l;
  logic [31:0]  m_old_lo, m_old_hi, m_new_lo, m_new_hi;
  logic         m_new_dbz;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(posedge clk) rd_seen <= cs && rd;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %08h expected no read", d_out);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, d_out, mon_exp);
      end
    end
  end

  function automatic logic m_busy(input longint t);
    return m_act && (t < m_n + m_l);
  endfunction

  function automatic logic m_fin(input longint t);
    return m_act && (t >= m_n + m_l);
  endfunction

  function automatic logic [31:0] m_reg(input longint t, input logic [2:0] sel);
    logic [31:0] s;
    s = {28'd0, SGN_SUP, 3'b000};
    if (m_busy(t)) begin
      s[0] = 1'b1;
    end else if (m_fin(t)) begin
      s[1] = 1'b1;
      s[2] = m_new_dbz;
    end
    case (sel)
      3'd0:    return 32'(m_a);
      3'd1:    return 32'(m_b);
      3'd3:    return s;
      3'd4:    return m_fin(t) ? m_new_lo : m_old_lo;
      3'd5:    return m_fin(t) ? m_new_hi : m_old_hi;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ext32(input longint v, input logic sgn);
    logic [W-1:0] t;
    t = v[W-1:0];
    return sgn ? {{(32-W){t[W-1]}}, t} : {{(32-W){1'b0}}, t};
  endfunction

  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic is_div,
                        input logic is_sgn, output logic [31:0] lo, output logic [31:0] hi,
                        output logic dbz);
    longint sa, sb, p, q, r;
    logic [63:0] p64;
    sa = longint'(a);
    sb = longint'(b);
    if (is_sgn && a[W-1]) sa = sa - (longint'(1) << W);
    if (is_sgn && b[W-1]) sb = sb - (longint'(1) << W);
    dbz = 1'b0;
    if (!is_div) begin
      p   = sa * sb;
      p64 = p;
      lo  = p64[31:0];
      hi  = p64[63:32];
    end else begin
      if (b == '0) begin
        dbz = 1'b1;
        q   = (longint'(1) << W) - 1;
        r   = longint'(a);
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
      lo = ext32(q, is_sgn);
      hi = ext32(r, is_sgn);
    end
  endtask

  // One bus access landing on the next rising edge.
  task automatic bus_cycle(input logic do_rd, input logic do_wr, input logic [2:0] sel,
                           input logic [31:0] data, input string n);
    longint      e;
    logic [31:0] rnd;
    logic        is_sgn;
    @(negedge clk);
    e   = edge_cnt + 1;
    rnd = $urandom();
    if (do_rd) begin
      exp_q.push_back(m_reg(e - 1, sel));
      name_q.push_back(n);
    end
    if (do_wr && !m_busy(e - 1)) begin
      case (sel)
        3'd0: m_a = data[W-1:0];
        3'd1: m_b = data[W-1:0];
        3'd2: begin
          m_old_lo = m_reg(e - 1, 3'd4);
          m_old_hi = m_reg(e - 1, 3'd5);
          is_sgn   = SGN_SUP & data[1];
          ref_op(m_a, m_b, data[0], is_sgn, m_new_lo, m_new_hi, m_new_dbz);
          m_n   = e;
          m_l   = W + (is_sgn ? 1 : 0);
          m_act = 1'b1;
        end
        default: ;
      endcase
    end
    cs   = 1'b1;
    rd   = do_rd;
    wr   = do_wr;
    addr = {rnd[31:5], sel, rnd[1:0]};
    d_in = data;
    @(posedge clk);
    #1;
    cs = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    m_a       = '0;
    m_b       = '0;
    m_act     = 1'b0;
    m_n       = 0;
    m_l       = 0;
    m_old_lo  = 32'd0;
    m_old_hi  = 32'd0;
    m_new_lo  = 32'd0;
    m_new_hi  = 32'd0;
    m_new_dbz = 1'b0;
    check("reset_dout", d_out, 32'd0);
  endtask

  task automatic read_all(input string tag);
    for (int s = 0; s < 8; s++) bus_cycle(1'b1, 1'b0, 3'(s), 32'd0, $sformatf("%s_reg%0d", tag, s));
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] ctrl,
                        input string tag);
    bus_cycle(1'b0, 1'b1, 3'd0, {16'hDEAD, a}, tag);
    bus_cycle(1'b0, 1'b1, 3'd1, {16'hBEEF, b}, tag);
    bus_cycle(1'b0, 1'b1, 3'd2, {30'd0, ctrl}, tag);
    for (int k = 0; k < W + 3; k++) bus_cycle(1'b1, 1'b0, 3'd3, 32'd0, {tag, "_status"});
    bus_cycle(1'b1, 1'b0, 3'd4, 32'd0, {tag, "_res_lo"});
    bus_cycle(1'b1, 1'b0, 3'd5, 32'd0, {tag, "_res_hi"});
  endtask

  logic [15:0] ra, rb;
  logic [1:0]  rc;

  initial begin
    m_a = '0; m_b = '0; m_act = 1'b0; m_n = 0; m_l = 0;
    m_old_lo = 32'd0; m_old_hi = 32'd0; m_new_lo = 32'd0; m_new_hi = 32'd0; m_new_dbz = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    read_all("reset");

    run_op(16'd300, 16'd200, 2'd0, "mul_300x200");
    run_op(16'hFFFF, 16'hFFFF, 2'd0, "mul_ffff");
    run_op(16'd1000, 16'd7, 2'd1, "div_1000_7");
    run_op(16'd1234, 16'd0, 2'd1, "div_by_zero");
    run_op(16'd1000, 16'd7, 2'd1, "div_after_dbz");
    bus_cycle(1'b0, 1'b1, 3'd2, 32'd0, "rerun");
    for (int k = 0; k < W + 2; k++) bus_cycle(1'b1, 1'b0, 3'd3, 32'd0, "rerun_status");
    bus_cycle(1'b1, 1'b0, 3'd4, 32'd0, "rerun_res_lo");

    // Writes during a multiply must be ignored.
    bus_cycle(1'b0, 1'b1, 3'd0, 32'h0000_1234, "busy");
    bus_cycle(1'b0, 1'b1, 3'd1, 32'h0000_0010, "busy");
    bus_cycle(1'b0, 1'b1, 3'd2, 32'd0, "busy");
    for (int k = 0; k < 4; k++) bus_cycle(1'b1, 1'b0, 3'd3, 32'd0, "busy_status");
    bus_cycle(1'b0, 1'b1, 3'd2, 32'd1, "busy_ctrl");
    bus_cycle(1'b1, 1'b1, 3'd0, 32'h0000_0055, "busy_wr_a");
    bus_cycle(1'b1, 1'b0, 3'd0, 32'd0, "busy_a_kept");
    bus_cycle(1'b1, 1'b0, 3'd4, 32'd0, "busy_old_res");
    for (int k = 0; k < 12; k++) bus_cycle(1'b1, 1'b0, 3'd3, 32'd0, "busy_status");
    bus_cycle(1'b1, 1'b0, 3'd4, 32'd0, "busy_res_lo");
    bus_cycle(1'b1, 1'b0, 3'd5, 32'd0, "busy_res_hi");

    bus_cycle(1'b1, 1'b1, 3'd0, 32'h0000_00AA, "rdwr_prewrite");
    bus_cycle(1'b1, 1'b0, 3'd0, 32'd0, "rdwr_after");
    bus_cycle(1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF, "wr_unmapped");
    bus_cycle(1'b1, 1'b0, 3'd6, 32'd0, "rd_unmapped");

    // Reset in the middle of a multiply.
    bus_cycle(1'b0, 1'b1, 3'd0, 32'd300, "mid");
    bus_cycle(1'b0, 1'b1, 3'd1, 32'd200, "mid");
    bus_cycle(1'b0, 1'b1, 3'd2, 32'd0, "mid");
    for (int k = 0; k < 7; k++) bus_cycle(1'b1, 1'b0, 3'd3, 32'd0, "mid_status");
    do_reset();
    read_all("mid_reset");
    run_op(16'd300, 16'd200, 2'd0, "after_reset");

    run_op(16'hFFF9, 16'd3, 2'd2, "smul_m7x3");
    run_op(16'hFFF9, 16'd2, 2'd3, "sdiv_m7_2");
    run_op(16'h8000, 16'hFFFF, 2'd3, "sdiv_ovf");
    run_op(16'h8000, 16'h0000, 2'd3, "sdiv_zero");
    run_op(16'h8000, 16'h8000, 2'd2, "smul_minmin");

    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom());
      rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom());
      rc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        ra = 16'h8000;
        rb = 16'hFFFF;
      end
      run_op(ra, rb, rc, $sformatf("rand%0d", i));
      bus_cycle(1'b1, 1'b0, 3'd0, 32'd0, "rand_a");
      bus_cycle(1'b1, 1'b0, 3'd1, 32'd0, "rand_b");
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/peripheral_muldiv.md
# peripheral_muldiv

Memory-mapped, parametrised iterative multiply/divide unit and successor to the fixed-function multiplier peripheral. It sits on the SoC data bus behind its own chip-select line, alongside the UART and RAM. Operand width is set by a parameter. One engine performs shift-add multiplication or restoring division, one bit per cycle, and software polls a status register for completion.

## Interface
- `WIDTH`, default 16: operand width in bits, legal range 2..32.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `d_in` in 32: write data (`mem_wdata`).
- `cs` in 1: chip select for this peripheral.
- `addr` in 32: byte address; only `addr[4:2]` is decoded.
- `rd` in 1: read strobe, qualified by `cs`.
- `wr` in 1: write strobe, qualified by `cs`.
- `d_out` out 32: registered read data.

## Operation
- Register map (`addr[4:2]`):
  - 0 `A` (RW): operand A, `d_in[WIDTH-1:0]`.
  - 1 `B` (RW): operand B.
  - 2 `CTRL` (W): bit0 selects op (0 = mul, 1 = div); bit1 selects signed. Any write starts an operation.
  - 3 `STATUS` (R): bit0 busy, bit1 done, bit2 div_by_zero, bit3 signed_supported.
  - 4 `RES_LO` (R).
  - 5 `RES_HI` (R).
  - 6–7: read 0, writes ignored.
- FSM states:
  - IDLE: a CTRL write latches op and sign, loads the working registers, clears done and div_by_zero, and moves to RUN.
  - RUN: iteration counter counts WIDTH-1 down to 0. Leaves for FIX if the signed op is taken, otherwise for IDLE with done set.
  - FIX: applies result negation, then moves to IDLE with done set.
- Multiply: product is 2·WIDTH bits, extended to 64 bits (zero-extend unsigned, sign-extend signed). `RES_LO` = [31:0], `RES_HI` = [63:32].
- Divide:
  - `RES_LO` = quotient, `RES_HI` = remainder, each WIDTH bits extended to 32 (zero- or sign-extend).
  - Signed mode: quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: the algorithm runs normally, quotient = all ones (WIDTH bits), remainder = A. div_by_zero is set at completion.
  - Signed overflow (most-negative / −1): quotient = most-negative value, remainder = 0.
- While busy:
  - Writes to A, B and CTRL are ignored; a restart is impossible.
  - Reads return live register contents. `RES_*` keep the previous result until completion.
- Completion:
  - done stays set until the next accepted CTRL write.
  - `A` and `B` keep their values, so a CTRL write alone reruns the operation.

## Timing
- Register writes take effect at the edge where `cs & wr` is high.
- Reads: `d_out` loads at the edge where `cs & rd` is high (1-cycle latency) and holds otherwise.
- CTRL write accepted at edge N:
  - busy = 1 from N.
  - Unsigned: busy falls and done rises at edge N+WIDTH.
  - Signed: busy falls and done rises at edge N+WIDTH+1.
- `RES_LO`/`RES_HI` update at the same edge done rises.
- Simultaneous `rd` and `wr`: the write is performed; `d_out` returns the pre-write value.
- Reset (any cycle, including mid-RUN):
  - state = IDLE, all registers 0, busy/done/div_by_zero = 0, `d_out` = 0.
  - The in-flight operation is discarded.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - CTRL bit1 is honoured; the FIX state and negation logic are built.
  - STATUS bit3 reads 1.
- `MULDIV_SIGNED_EN` undefined:
  - CTRL bit1 is ignored and every operation is unsigned; no FIX state is built.
  - STATUS bit3 reads 0.

## Test plan
- (WIDTH = 16 throughout.)
- Multiply unsigned:
  - A = 300, B = 200, CTRL = 0 → busy for exactly 16 cycles, then `RES_LO` = 0x0000EA60, `RES_HI` = 0, STATUS = 0x2|bit3.
  - A = B = 0xFFFF → `RES_LO` = 0xFFFE0001.
- Divide unsigned: A = 1000, B = 7, CTRL = 1 → `RES_LO` = 0x8E, `RES_HI` = 6.
- Divide by zero: A = 1234, B = 0, CTRL = 1 → `RES_LO` = 0xFFFF, `RES_HI` = 0x4D2, div_by_zero = 1. A following valid op clears it.
- Busy protection:
  - CTRL write 5 cycles into a multiply → ignored; the original result and latency are unchanged.
  - A write while busy → A unchanged.
- Reset mid-op: reset at cycle 8 of a multiply → all reads return 0, STATUS = bit3 only. A new op then runs correctly.
- Signed (`MULDIV_SIGNED_EN` defined):
  - −7 × 3 (CTRL = 2) → `RES_LO` = 0xFFFFFFEB, `RES_HI` = 0xFFFFFFFF, done at N+17.
  - −7 ÷ 2 (CTRL = 3) → `RES_LO` = 0xFFFFFFFD, `RES_HI` = 0xFFFFFFFF.
  - 0x8000 ÷ 0xFFFF (CTRL = 3) → `RES_LO` = 0xFFFF8000, `RES_HI` = 0.
  - Macro undefined: CTRL = 2 on 0xFFF9 × 3 → `RES_LO` = 0x0002FFEB.
